// File: rtl/fmult_pipe.sv
// Pipelined multi-lane signed fixed-point multiplier with valid/ready
// handshake, selectable rounding/saturation and per-lane overflow flags.
module fmult_pipe #(
  parameter int WIDTH  = 16,
  parameter int FRAC   = 8,
  parameter int LANES  = 1,
  parameter int STAGES = 2,
  parameter int ROUND  = 1,
  parameter int SAT    = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [LANES*WIDTH-1:0] i_multiplicand,
  input  logic [LANES*WIDTH-1:0] i_multiplier,
  input  logic [LANES-1:0]       i_ovr,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [LANES*WIDTH-1:0] o_result,
  output logic [LANES-1:0]       o_ovr,
  output logic [LANES-1:0]       o_ovr_sticky,
  input  logic                   i_ovr_clr
);

  localparam int PW = 2*WIDTH;
  localparam int EW = PW+1;
  localparam int NP = (STAGES > 1) ? STAGES-1 : 1;

  logic advance;
  assign advance = i_ready | ~o_valid;
  assign o_ready = advance;

  // {overflow, result} for one lane's full product
  function automatic logic [WIDTH:0] convert(input logic [PW-1:0] p);
    logic signed [EW-1:0] e;
    logic signed [EW-1:0] r;
    logic                 ov;
    logic [WIDTH-1:0]     res;
    e = {p[PW-1], p};
    if (ROUND != 0)
      e = e + EW'(1 << (FRAC-1));
    r  = e >>> FRAC;
    ov = r[EW-1:WIDTH-1] != {(EW-WIDTH+1){r[EW-1]}};
    if (ov && SAT != 0)
      res = r[EW-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                    : {1'b0, {(WIDTH-1){1'b1}}};
    else
      res = r[WIDTH-1:0];
    return {ov, res};
  endfunction

  logic [LANES-1:0][PW-1:0]    prod_in;
  logic [LANES-1:0][PW-1:0]    cv_p;
  logic [LANES-1:0]            cv_o;
  logic                        cv_v;
  logic [LANES-1:0][WIDTH:0]   conv;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign prod_in[k] =
      $signed(i_multiplicand[k*WIDTH +: WIDTH]) *
      $signed(i_multiplier[k*WIDTH +: WIDTH]);
    assign conv[k] = convert(cv_p[k]);
  end

  logic [NP-1:0]                       pv;
  logic [NP-1:0][LANES-1:0][PW-1:0]    pp;
  logic [NP-1:0][LANES-1:0]            po;

  if (STAGES > 1) begin : g_pipe
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        pv <= '0;
        pp <= '0;
        po <= '0;
      end else if (advance) begin
        pv[0] <= i_valid;
        pp[0] <= prod_in;
        po[0] <= i_ovr;
        for (int s = 1; s < NP; s++) begin
          pv[s] <= pv[s-1];
          pp[s] <= pp[s-1];
          po[s] <= po[s-1];
        end
      end
    end
    assign cv_p = pp[NP-1];
    assign cv_o = po[NP-1];
    assign cv_v = pv[NP-1];
  end else begin : g_comb
    // single-stage build: conversion feeds the output register directly
    assign pv   = '0;
    assign pp   = '0;
    assign po   = '0;
    assign cv_p = prod_in;
    assign cv_o = i_ovr;
    assign cv_v = i_valid;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid  <= 1'b0;
      o_result <= '0;
      o_ovr    <= '0;
    end else if (advance) begin
      o_valid <= cv_v;
      for (int k = 0; k < LANES; k++) begin
        o_result[k*WIDTH +: WIDTH] <= conv[k][WIDTH-1:0];
        o_ovr[k] <= cv_o[k] | conv[k][WIDTH];
      end
    end
  end

  logic deliver;
  assign deliver = o_valid & i_ready;

  // set beats clear when both land in the same cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      o_ovr_sticky <= '0;
    else
      o_ovr_sticky <= (i_ovr_clr ? '0 : o_ovr_sticky)
                    | (deliver ? o_ovr : '0);
  end

endmodule

// File: tb/tb_fmult_pipe.sv
// Directed bench for fmult_pipe: two builds (round+sat, floor+wrap)
// share stimulus; vector table plus handshake/sticky/reset sequences.
module tb_fmult_pipe;

  localparam int W = 16;
  localparam int L = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           i_valid = 1'b0;
  logic           i_ready = 1'b1;
  logic           i_ovr_clr = 1'b0;
  logic [L*W-1:0] a = '0;
  logic [L*W-1:0] b = '0;
  logic [L-1:0]   ovr_in = '0;

  logic           rdy_a, vld_a, rdy_b, vld_b;
  logic [L*W-1:0] res_a, res_b;
  logic [L-1:0]   ov_a, ov_b, st_a, st_b;

  fmult_pipe #(
    .WIDTH(16), .FRAC(8), .LANES(2),
    .STAGES(2), .ROUND(1), .SAT(1)
  ) dut_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_valid(i_valid), .o_ready(rdy_a),
    .i_multiplicand(a), .i_multiplier(b),
    .i_ovr(ovr_in), .o_valid(vld_a),
    .i_ready(i_ready), .o_result(res_a),
    .o_ovr(ov_a), .o_ovr_sticky(st_a),
    .i_ovr_clr(i_ovr_clr)
  );

  fmult_pipe #(
    .WIDTH(16), .FRAC(8), .LANES(2),
    .STAGES(2), .ROUND(0), .SAT(0)
  ) dut_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_valid(i_valid), .o_ready(rdy_b),
    .i_multiplicand(a), .i_multiplier(b),
    .i_ovr(ovr_in), .o_valid(vld_b),
    .i_ready(i_ready), .o_result(res_b),
    .o_ovr(ov_b), .o_ovr_sticky(st_b),
    .i_ovr_clr(i_ovr_clr)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  ov;
    logic [31:0] ra;
    logic [1:0]  oa;
    logic [31:0] rb;
    logic [1:0]  ob;
  } vec_t;

  vec_t tbl[7];

  logic [31:0] hold;
  logic [31:0] expv;
  logic [15:0] k16;
  logic        stalled;
  logic        seen;
  int          sent;
  int          recv;

  initial begin
    tbl[0] = '{32'hFE80_0180, 32'h0200_0200, 2'b00,
               32'hFD00_0300, 2'b00, 32'hFD00_0300, 2'b00};
    tbl[1] = '{32'h8000_7F00, 32'h8000_0200, 2'b00,
               32'h7FFF_7FFF, 2'b11, 32'h0000_FE00, 2'b11};
    tbl[2] = '{32'hFFFF_0001, 32'h0080_0080, 2'b00,
               32'h0000_0001, 2'b00, 32'hFFFF_0000, 2'b00};
    tbl[3] = '{32'h7FFF_8000, 32'h0100_7FFF, 2'b00,
               32'h7FFF_8000, 2'b01, 32'h7FFF_0080, 2'b01};
    tbl[4] = '{32'hFF00_0100, 32'h0100_0100, 2'b01,
               32'hFF00_0100, 2'b01, 32'hFF00_0100, 2'b01};
    tbl[5] = '{32'h0003_FFFF, 32'h0080_0180, 2'b00,
               32'h0002_FFFF, 2'b00, 32'h0001_FFFE, 2'b00};
    tbl[6] = '{32'h4000_8000, 32'h0200_0100, 2'b00,
               32'h7FFF_8000, 2'b10, 32'h8000_8000, 2'b10};

    // reset state
    #1;
    chk("rst_valid", 64'(vld_a), 64'(0));
    chk("rst_result", 64'(res_a), 64'(0));
    chk("rst_ovr", 64'({ov_a, ov_b}), 64'(0));
    chk("rst_sticky", 64'({st_a, st_b}), 64'(0));
    chk("rst_ready", 64'({rdy_a, rdy_b}), 64'(2'b11));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // vector table, one beat at a time
    for (int i = 0; i < 7; i++) begin
      a = tbl[i].a;
      b = tbl[i].b;
      ovr_in = tbl[i].ov;
      i_valid = 1'b1;
      @(negedge clk);
      i_valid = 1'b0;
      ovr_in = '0;
      chk($sformatf("v%0d_early", i), 64'(vld_a), 64'(0));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), 64'({vld_a, vld_b}), 64'(2'b11));
      chk($sformatf("v%0d_res_a", i), 64'(res_a), 64'(tbl[i].ra));
      chk($sformatf("v%0d_ovr_a", i), 64'(ov_a), 64'(tbl[i].oa));
      chk($sformatf("v%0d_res_b", i), 64'(res_b), 64'(tbl[i].rb));
      chk($sformatf("v%0d_ovr_b", i), 64'(ov_b), 64'(tbl[i].ob));
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    chk("sticky_after_tbl", 64'({st_a, st_b}), 64'(4'b1111));

    // sticky clear, then clear colliding with a set
    @(negedge clk);
    i_ovr_clr = 1'b1;
    @(negedge clk);
    i_ovr_clr = 1'b0;
    chk("sticky_clr", 64'(st_a), 64'(0));
    a = 32'h0100_0100;
    b = 32'h0100_0100;
    ovr_in = 2'b01;
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    ovr_in = '0;
    @(negedge clk);
    chk("ovr_prop", 64'(ov_a), 64'(2'b01));
    chk("sticky_pre", 64'(st_a), 64'(0));
    i_ovr_clr = 1'b1;
    @(negedge clk);
    i_ovr_clr = 1'b0;
    chk("sticky_set_wins", 64'(st_a), 64'(2'b01));
    i_ovr_clr = 1'b1;
    @(negedge clk);
    i_ovr_clr = 1'b0;
    chk("sticky_clr2", 64'(st_a), 64'(0));

    // backpressure stream of 8 beats
    sent = 0;
    recv = 0;
    stalled = 1'b0;
    hold = '0;
    b = 32'hFF00_0100;
    for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
      @(negedge clk);
      i_ready = !(cyc >= 4 && cyc <= 6);
      i_valid = (sent < 8);
      k16 = 16'(sent + 1);
      a = {k16[7:0], 8'h00, k16[7:0], 8'h00};
      #1;
      if (stalled) chk("stall_hold", 64'(res_a), 64'(hold));
      chk("o_ready", 64'(rdy_a), 64'(!(vld_a && !i_ready)));
      if (vld_a && i_ready) begin
        k16 = 16'(recv + 1);
        expv = {16'(16'h0 - (k16 << 8)), 16'(k16 << 8)};
        chk($sformatf("bp_beat%0d", recv), 64'(res_a), 64'(expv));
        recv++;
      end
      stalled = vld_a && !i_ready;
      hold = res_a;
      if (i_valid && rdy_a) sent++;
    end
    chk("bp_count", 64'(recv), 64'(8));
    @(negedge clk);
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // reset with beats in flight
    a = 32'h0100_0100;
    b = 32'h0100_0100;
    ovr_in = 2'b11;
    i_valid = 1'b1;
    @(negedge clk);
    ovr_in = 2'b00;
    @(negedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    chk("rst_pre_sticky", 64'(st_a), 64'(2'b11));
    chk("rst_pre_valid", 64'(vld_a), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(vld_a), 64'(0));
    chk("rst_mid_result", 64'(res_a), 64'(0));
    chk("rst_mid_sticky", 64'(st_a), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (vld_a || vld_b) seen = 1'b1;
    end
    chk("no_stale_beat", 64'(seen), 64'(0));

    // normal operation after release
    a = tbl[0].a;
    b = tbl[0].b;
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_res", 64'(res_a), 64'(tbl[0].ra));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fmult_pipe.md
# fmult_pipe

Pipelined, multi-lane signed fixed-point multiplier with a valid/ready handshake, selectable rounding and saturation, and per-lane overflow reporting. It is the registered successor to the team's combinational fixed-point multiplier and sits in the adaptive-filter datapath between the coefficient/sample stores and the accumulator. The handshake lets the accumulator apply backpressure. Q-format in equals Q-format out: WIDTH total bits, FRAC fractional bits.

## Interface
- WIDTH, 16, operand and result width (two's complement), ≥ 4
- FRAC, 8, fractional bits of operands and result, 1 ≤ FRAC < WIDTH
- LANES, 1, parallel independent multipliers sharing one handshake
- STAGES, 2, pipeline depth (accept-to-output latency in cycles), ≥ 1
- ROUND, 1, 0 = truncate (floor), 1 = round-half-up
- SAT, 1, 0 = wrap on overflow, 1 = clamp to max/min

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  input beat valid
- o_ready  out  1  block can accept a beat this cycle
- i_multiplicand  in  LANES*WIDTH  packed operands, lane k at [k*WIDTH +: WIDTH]
- i_multiplier  in  LANES*WIDTH  packed operands, same packing
- i_ovr  in  LANES  upstream overflow flag per lane, carried with the beat
- o_valid  out  1  output beat valid
- i_ready  in  1  downstream accepts output
- o_result  out  LANES*WIDTH  packed results
- o_ovr  out  LANES  per-lane overflow for the current output beat: i_ovr OR conversion overflow
- o_ovr_sticky  out  LANES  per-lane sticky overflow, set by any accepted output beat with o_ovr high
- i_ovr_clr  in  1  synchronous clear of o_ovr_sticky

## Operation
- Per lane, the full product P = a*b is 2*WIDTH bits signed, with 2*FRAC fractional bits.
- Rounding:
  - ROUND=0: R = P >>> FRAC (arithmetic shift).
  - ROUND=1: R = (P + 2^(FRAC-1)) >>> FRAC, computed at 2*WIDTH+1 bits so the add cannot wrap.
- Overflow is flagged when R lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - SAT=1: the result clamps to 0x7F..F or 0x80..0.
  - SAT=0: the result is the low WIDTH bits of R.
- o_ovr lane k = i_ovr[k] of that beat OR the lane-k conversion overflow.
- The handshake uses a global-enable pipeline.
  - advance = i_ready | ~o_valid. o_ready = advance.
  - A beat is accepted when i_valid & o_ready. A beat is delivered when o_valid & i_ready.
  - When advance=1, every stage shifts one place and stage 0 captures the input, with valid = i_valid.
  - When advance=0, every stage holds.
- Only the product and conversion are split across stages. Placement is implementation choice, but the rounding/saturation logic is registered no earlier than stage 1.
- The output registers are stable while o_valid & ~i_ready.
- Sticky flags:
  - o_ovr_sticky[k] sets on delivery of a beat with o_ovr[k]=1.
  - i_ovr_clr clears all lanes.
  - If a clear and a set happen in the same cycle, the set wins.
- Lanes are fully independent apart from the shared handshake.

## Timing
- Reset (i_rst_n low, asynchronous) forces:
  - o_valid=0, o_result=0, o_ovr=0, o_ovr_sticky=0.
  - All internal valid bits cleared. In-flight beats are discarded.
- o_ready is combinational from i_ready and o_valid. It reads 1 during and after reset.
- Latency: a beat accepted at edge n appears with o_valid=1 after edge n+STAGES-1, provided the pipeline is not stalled.
- Throughput is one beat per cycle with i_ready held high.
- A stall of s cycles adds exactly s cycles to every in-flight beat. No beat is dropped or duplicated.
- Bubbles do not collapse while advance=1. When o_valid=0, advance=1, so bubbles ahead of the output drain.
- Release from reset is asynchronous assert, with deassert on the clock edge. The first beat can be accepted on the first edge with i_rst_n high.

## Test plan
- Lane throughput, WIDTH=16, FRAC=8, STAGES=2, LANES=2.
  - Stimulus: lane0 0x0180*0x0200, lane1 0xFE80*0x0200.
  - Response: after 2 cycles o_result = {0xFD00, 0x0300}, o_ovr=0.
- Saturation, SAT=1.
  - Stimulus: 0x7F00*0x0200, then 0x8000*0x8000.
  - Response: 0x7FFF with o_ovr=1 for both. With SAT=0, results are 0xFE00 and 0x0000 with o_ovr=1.
- Rounding.
  - Stimulus: 0x0001*0x0080 and 0xFFFF*0x0080.
  - Response: ROUND=0 gives 0x0000 and 0xFFFF. ROUND=1 gives 0x0001 and 0x0000. o_ovr=0 in all cases.
- Backpressure.
  - Stimulus: stream 8 beats with values 1..8 times 0x0100, holding i_ready=0 for 3 cycles mid-stream.
  - Response: all 8 results delivered in order, unchanged while stalled. o_ready=0 exactly while o_valid & ~i_ready.
- Overflow propagation and sticky.
  - Stimulus: i_ovr[0]=1 on a benign product.
  - Response: o_ovr[0]=1 on delivery and o_ovr_sticky[0] sets.
  - Stimulus: pulse i_ovr_clr in the same cycle as another overflow delivery.
  - Response: sticky stays 1. A later clear alone drops it to 0.
- Reset mid-stream.
  - Stimulus: assert i_rst_n=0 with 2 beats in flight.
  - Response: o_valid, o_result and sticky go to 0 immediately. No stale beat emerges after release.
